// File: rtl/ledger_balance_reader_pkg.sv
// Shared definitions for the ledger read-back path:
// BCD sizing, segment codes, FSM states, double-dabble helper.
package ledger_balance_reader_pkg;

    localparam int LBR_BCD_DIGITS = 8;
    localparam int LBR_BCD_WIDTH  = 4 * LBR_BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_LOAD,
        S_CONV,
        S_SHOW
    } state_e;

    // Double-dabble correction for one BCD nibble.
    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/ledger_balance_reader_seg7.sv
// Nibble to active-low 7-segment code {g,f,e,d,c,b,a}.
// Non-decimal nibbles show blank.
module ledger_balance_reader_seg7
    import ledger_balance_reader_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure lookup; blanking and dashes are handled by the parent.
    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/ledger_balance_reader.sv
// Reads one ledger word, picks a player's balance, converts it
// to BCD serially and drives six blanked active-low HEX digits.
module ledger_balance_reader
    import ledger_balance_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 48,
    parameter int BAL_WIDTH    = 24,
    parameter int DIGITS       = 6,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  player_sel,
    output logic                  mem_rden,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [6:0]            hex0,
    output logic [6:0]            hex1,
    output logic [6:0]            hex2,
    output logic [6:0]            hex3,
    output logic [6:0]            hex4,
    output logic [6:0]            hex5
);

    localparam int CNT_MAX = (BAL_WIDTH > READ_LATENCY) ? BAL_WIDTH : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int SHW     = LBR_BCD_WIDTH + BAL_WIDTH;

    state_e                    state_q;
    logic                      sel_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [BAL_WIDTH-1:0]      shreg_q;
    logic [LBR_BCD_WIDTH-1:0]  bcd_q;
    logic                      rden_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      ovf_q;
    logic [DIGITS-1:0][6:0]    hex_q;

    logic [LBR_BCD_WIDTH-1:0]  bcd_adj;
    logic [SHW-1:0]            shift_d;
    logic [BAL_WIDTH-1:0]      bal_sel;
    logic [DIGITS-1:0][6:0]    seg_raw;
    logic [DIGITS-1:0][6:0]    hex_d;
    logic                      ovf_d;
    logic                      seen;

    // One double-dabble step: correct every nibble, then shift.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < LBR_BCD_DIGITS; i++) begin
            bcd_adj[i*4 +: 4] = dd_adjust(bcd_q[i*4 +: 4]);
        end
        shift_d = {bcd_adj, shreg_q} << 1;
    end

    // Balance half chosen by the player latched at start.
    always_comb begin
        bal_sel = sel_q ? mem_rdata[DATA_WIDTH-1 -: BAL_WIDTH]
                        : mem_rdata[BAL_WIDTH-1:0];
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        ledger_balance_reader_seg7 u_seg (
            .nibble_i (bcd_q[g*4 +: 4]),
            .seg_o    (seg_raw[g])
        );
    end

    // Display image: dashes on overflow, else leading-zero blanking.
    always_comb begin
        ovf_d = |bcd_q[LBR_BCD_WIDTH-1 : DIGITS*4];
        seen  = 1'b0;
        hex_d = {DIGITS{SEG_BLANK}};
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen = seen | (bcd_q[i*4 +: 4] != 4'd0);
            if (ovf_d) begin
                hex_d[i] = SEG_DASH;
            end else if (!seen && i != 0) begin
                hex_d[i] = SEG_BLANK;
            end else begin
                hex_d[i] = seg_raw[i];
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            shreg_q <= '0;
            bcd_q   <= '0;
            rden_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            hex_q   <= {DIGITS{SEG_BLANK}};
        end else begin
            rden_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q   <= player_sel;
                        ovf_q   <= 1'b0;
                        rden_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Take the data on the cycle it is first valid;
                    // the RAM need not hold it any longer.
                    if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
                        shreg_q <= bal_sel;
                        state_q <= S_LOAD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_LOAD: begin
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= S_CONV;
                end
                S_CONV: begin
                    bcd_q   <= shift_d[SHW-1 -: LBR_BCD_WIDTH];
                    shreg_q <= shift_d[BAL_WIDTH-1:0];
                    if (cnt_q == CNT_W'(BAL_WIDTH - 1)) begin
                        state_q <= S_SHOW;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SHOW: begin
                    hex_q   <= hex_d;
                    ovf_q   <= ovf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rden = rden_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign hex0     = hex_q[0];
    assign hex1     = hex_q[1];
    assign hex2     = hex_q[2];
    assign hex3     = hex_q[3];
    assign hex4     = hex_q[4];
    assign hex5     = hex_q[5];

endmodule

// File: tb/tb_ledger_balance_reader.sv
// Directed bench for ledger_balance_reader: vector table plus
// hand sequences for restart, mid-op reset and slow RAM.
module tb_ledger_balance_reader;

    localparam logic [6:0] D0 = 7'h40, D1 = 7'h79, D2 = 7'h24, D3 = 7'h30;
    localparam logic [6:0] D4 = 7'h19, D5 = 7'h12, D6 = 7'h02, D7 = 7'h78;
    localparam logic [6:0] D8 = 7'h00, D9 = 7'h10, BL = 7'h7F, DS = 7'h3F;

    logic        clk;
    logic        reset;
    logic        start1, start3;
    logic        player_sel;
    logic        rden1, rden3;
    logic [47:0] rdata1, rdata3;
    logic [47:0] word1, word3;
    logic        busy1, busy3, done1, done3, ovf1, ovf3;
    logic [6:0]  h1_0, h1_1, h1_2, h1_3, h1_4, h1_5;
    logic [6:0]  h3_0, h3_1, h3_2, h3_3, h3_4, h3_5;
    logic [2:0]  pipe3;
    logic        use3;

    int n_chk;
    int n_fail;

    ledger_balance_reader u_dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start1),
        .player_sel (player_sel),
        .mem_rden   (rden1),
        .mem_rdata  (rdata1),
        .busy       (busy1),
        .done       (done1),
        .overflow   (ovf1),
        .hex0       (h1_0),
        .hex1       (h1_1),
        .hex2       (h1_2),
        .hex3       (h1_3),
        .hex4       (h1_4),
        .hex5       (h1_5)
    );

    ledger_balance_reader #(.READ_LATENCY(3)) u_dut3 (
        .clock      (clk),
        .reset      (reset),
        .start      (start3),
        .player_sel (player_sel),
        .mem_rden   (rden3),
        .mem_rdata  (rdata3),
        .busy       (busy3),
        .done       (done3),
        .overflow   (ovf3),
        .hex0       (h3_0),
        .hex1       (h3_1),
        .hex2       (h3_2),
        .hex3       (h3_3),
        .hex4       (h3_4),
        .hex5       (h3_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (rden1) rdata1 <= word1;
    end

    // RAM with three-cycle latency; garbage until the data lands.
    always @(posedge clk) begin
        logic [2:0] pn;
        pn = {pipe3[1:0], rden3};
        pipe3 <= pn;
        if (pn[2]) rdata3 <= word3;
        else if (rden3) rdata3 <= 48'hBADBAD_BADBAD;
    end

    wire        w_done = use3 ? done3 : done1;
    wire        w_busy = use3 ? busy3 : busy1;
    wire        w_ovf  = use3 ? ovf3  : ovf1;
    wire        w_rden = use3 ? rden3 : rden1;
    wire [41:0] w_hex  = use3 ? {h3_5, h3_4, h3_3, h3_2, h3_1, h3_0}
                              : {h1_5, h1_4, h1_3, h1_2, h1_1, h1_0};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One operation observed over a fixed 40-cycle window.
    task automatic run_op(
        input  bit          which,
        input  logic [47:0] w,
        input  bit          sel,
        input  int          poke_at,
        input  int          rst_at,
        output int          first_done,
        output int          n_done,
        output int          n_rden,
        output bit          busy0,
        output bit          ovf0,
        output bit          rst_busy,
        output logic [41:0] rst_hex,
        output logic [41:0] fin_hex,
        output bit          fin_ovf
    );
        use3 = which;
        @(negedge clk);
        if (which) word3 = w; else word1 = w;
        player_sel = sel;
        if (which) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start3 = 1'b0;
        player_sel = ~sel;
        busy0 = w_busy;
        ovf0 = w_ovf;
        n_rden = w_rden ? 1 : 0;
        first_done = 0;
        n_done = 0;
        rst_busy = 1'b0;
        rst_hex = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == poke_at) begin
                if (which) start3 = 1'b1; else start1 = 1'b1;
            end
            if (c == rst_at) reset = 1'b1;
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start3 = 1'b0;
            reset = 1'b0;
            if (w_rden) n_rden++;
            if (w_done) begin
                n_done++;
                if (first_done == 0) first_done = c;
            end
            if (c == rst_at) begin
                rst_busy = w_busy;
                rst_hex = w_hex;
            end
        end
        fin_hex = w_hex;
        fin_ovf = w_ovf;
    endtask

    typedef struct {
        logic [47:0] word;
        bit          sel;
        logic [41:0] hex;
        bit          ovf;
    } vec_t;

    vec_t vt[10];

    initial begin
        int fd, nd, nr;
        bit b0, o0, rb, fo;
        logic [41:0] rh, fh;

        n_chk = 0;
        n_fail = 0;

        vt[0] = '{{24'd42, 24'd0},        1'b0, {BL, BL, BL, BL, BL, D0}, 1'b0};
        vt[1] = '{{24'd42, 24'd123456},   1'b0, {D1, D2, D3, D4, D5, D6}, 1'b0};
        vt[2] = '{{24'd42, 24'd123456},   1'b1, {BL, BL, BL, BL, D4, D2}, 1'b0};
        vt[3] = '{{24'd7, 24'd1000000},   1'b0, {DS, DS, DS, DS, DS, DS}, 1'b1};
        vt[4] = '{{24'd0, 24'd999999},    1'b0, {D9, D9, D9, D9, D9, D9}, 1'b0};
        vt[5] = '{{24'd16777215, 24'd5},  1'b1, {DS, DS, DS, DS, DS, DS}, 1'b1};
        vt[6] = '{{24'd100, 24'd7},       1'b0, {BL, BL, BL, BL, BL, D7}, 1'b0};
        vt[7] = '{{24'd100, 24'd7},       1'b1, {BL, BL, BL, D1, D0, D0}, 1'b0};
        vt[8] = '{{24'd0, 24'd105030},    1'b0, {D1, D0, D5, D0, D3, D0}, 1'b0};
        vt[9] = '{{24'd8, 24'd987654},    1'b1, {BL, BL, BL, BL, BL, D8}, 1'b0};

        reset = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        player_sel = 1'b0;
        word1 = '0;
        word3 = '0;
        use3 = 1'b0;
        pipe3 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hex", 64'({h1_5, h1_4, h1_3, h1_2, h1_1, h1_0}), 64'({6{BL}}));
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_ovf", 64'(ovf1), 64'd0);
        chk("rst_rden", 64'(rden1), 64'd0);
        chk("rst3_hex", 64'({h3_5, h3_4, h3_3, h3_2, h3_1, h3_0}), 64'({6{BL}}));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(1'b0, vt[i].word, vt[i].sel, 0, 0,
                   fd, nd, nr, b0, o0, rb, rh, fh, fo);
            chk($sformatf("v%0d_hex", i), 64'(fh), 64'(vt[i].hex));
            chk($sformatf("v%0d_ovf", i), 64'(fo), 64'(vt[i].ovf));
            chk($sformatf("v%0d_lat", i), 64'(fd), 64'd28);
            chk($sformatf("v%0d_ndone", i), 64'(nd), 64'd1);
            chk($sformatf("v%0d_nrden", i), 64'(nr), 64'd1);
            chk($sformatf("v%0d_busy", i), 64'(b0), 64'd1);
            chk($sformatf("v%0d_ovfclr", i), 64'(o0), 64'd0);
        end

        // Extra start pulse in the middle of an operation.
        run_op(1'b0, {24'd0, 24'd654321}, 1'b0, 10, 0,
               fd, nd, nr, b0, o0, rb, rh, fh, fo);
        chk("poke_lat", 64'(fd), 64'd28);
        chk("poke_ndone", 64'(nd), 64'd1);
        chk("poke_nrden", 64'(nr), 64'd1);
        chk("poke_hex", 64'(fh), 64'({D6, D5, D4, D3, D2, D1}));

        // Reset during conversion, then a clean operation.
        run_op(1'b0, {24'd0, 24'd777}, 1'b0, 0, 15,
               fd, nd, nr, b0, o0, rb, rh, fh, fo);
        chk("midrst_busy", 64'(rb), 64'd0);
        chk("midrst_hex", 64'(rh), 64'({6{BL}}));
        chk("midrst_ndone", 64'(nd), 64'd0);
        chk("midrst_fin_hex", 64'(fh), 64'({6{BL}}));
        run_op(1'b0, {24'd31, 24'd0}, 1'b1, 0, 0,
               fd, nd, nr, b0, o0, rb, rh, fh, fo);
        chk("after_rst_lat", 64'(fd), 64'd28);
        chk("after_rst_hex", 64'(fh), 64'({BL, BL, BL, BL, D3, D1}));

        // Three-cycle RAM build.
        run_op(1'b1, {24'd5, 24'd314159}, 1'b0, 0, 0,
               fd, nd, nr, b0, o0, rb, rh, fh, fo);
        chk("rl3_lat", 64'(fd), 64'd30);
        chk("rl3_ndone", 64'(nd), 64'd1);
        chk("rl3_nrden", 64'(nr), 64'd1);
        chk("rl3_hex", 64'(fh), 64'({D3, D1, D4, D1, D5, D9}));
        chk("rl3_ovf", 64'(fo), 64'd0);
        run_op(1'b1, {24'd5, 24'd314159}, 1'b1, 0, 0,
               fd, nd, nr, b0, o0, rb, rh, fh, fo);
        chk("rl3_p1_lat", 64'(fd), 64'd30);
        chk("rl3_p1_hex", 64'(fh), 64'({BL, BL, BL, BL, BL, D5}));

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
